logic_unit_pipe: RTL and testbench

LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

---
 rtl/logic_unit_pipe.sv | 125 ++++++++++++
 tb/tb_logic_unit_pipe.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with popcount and zero/ones flags.
// S1 registers the request, S2 registers the result; both stages backpressure-safe.
module logic_unit_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             zero_flag,
  output logic             ones_flag
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
  // A producer holds valid and data until the transfer; ready never depends on valid.

  logic             s1_valid_q, s1_valid_d;
  logic [2:0]       s1_op_q, s1_op_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic             zero_q, zero_d;
  logic             ones_q, ones_d;

  logic             in_fire;
  logic             out_fire;
  logic             s2_load;
  logic [WIDTH-1:0] ab_or;
  logic [WIDTH-1:0] pop;
  logic [WIDTH-1:0] result;

  always_comb begin
    out_fire = s2_valid_q & out_ready;
    s2_load  = s1_valid_q & (~s2_valid_q | out_ready);
    in_ready = ~s1_valid_q | s2_load;
    in_fire  = in_valid & in_ready;
  end

  // Count accumulates at full WIDTH so the all-ones case (value WIDTH) fits for WIDTH >= 2.
  always_comb begin
    ab_or = s1_a_q | s1_b_q;
    pop   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + WIDTH'(ab_or[i]);
    end
  end

  always_comb begin
    result = '0;
    case (s1_op_q)
      3'b000:  result = s1_a_q & s1_b_q;
      3'b001:  result = s1_a_q | s1_b_q;
      3'b010:  result = s1_a_q ^ s1_b_q;
      3'b011:  result = ~(s1_a_q | s1_b_q);
      3'b100:  result = ~(s1_a_q & s1_b_q);
      3'b101:  result = ~(s1_a_q ^ s1_b_q);
      3'b110:  result = ~s1_a_q;
      default: result = pop;
    endcase
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s2_valid_d = s2_valid_q;
    z_d        = z_q;
    zero_d     = zero_q;
    ones_d     = ones_q;

    if (s2_load) begin
      s2_valid_d = 1'b1;
      z_d        = result;
      zero_d     = (result == '0);
      ones_d     = &result;
    end else if (out_fire) begin
      s2_valid_d = 1'b0;
    end

    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_op_d    = op;
      s1_a_d     = a;
      s1_b_d     = b;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_valid_q <= 1'b0;
      z_q        <= '0;
      zero_q     <= 1'b1;
      ones_q     <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s2_valid_q <= s2_valid_d;
      z_q        <= z_d;
      zero_q     <= zero_d;
      ones_q     <= ones_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign z         = z_q;
  assign zero_flag = zero_q;
  assign ones_flag = ones_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: scoreboard on a 32-bit instance plus
// a directed popcount check on an 8-bit instance.
module tb_logic_unit_pipe;

  logic        clock = 1'b0;
  logic        clear;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [2:0]  op;
  logic [31:0] a, b, z;
  logic        zero_flag, ones_flag;

  logic        in8_valid, in8_ready, out8_valid, out8_ready;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, z8;
  logic        zero8, ones8;

  int checks = 0;
  int errors = 0;
  int accept_cnt = 0;
  logic stream_done;

  // Entry layout: {z, zero_flag, ones_flag}
  logic [33:0] exp_q[$];

  always #5 clock = ~clock;

  logic_unit_pipe #(.WIDTH(32)) dut (
    .clock(clock), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .z(z), .zero_flag(zero_flag), .ones_flag(ones_flag)
  );

  logic_unit_pipe #(.WIDTH(8)) dut8 (
    .clock(clock), .clear(clear), .in_valid(in8_valid), .in_ready(in8_ready),
    .op(op8), .a(a8), .b(b8), .out_valid(out8_valid), .out_ready(out8_ready),
    .z(z8), .zero_flag(zero8), .ones_flag(ones8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    case (f)
      3'd0: return x & y;
      3'd1: return x | y;
      3'd2: return x ^ y;
      3'd3: return ~(x | y);
      3'd4: return ~(x & y);
      3'd5: return ~(x ^ y);
      3'd6: return ~x;
      default: return 32'($countones(x | y));
    endcase
  endfunction

  function automatic logic [33:0] pack_exp(input logic [31:0] ez);
    return {ez, (ez == 32'd0), (ez == 32'hFFFF_FFFF)};
  endfunction

  // Presents one request and waits (bounded) until it is accepted.
  task automatic send(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] ez);
    logic accepted;
    int   n;
    in_valid = 1'b1;
    op = f; a = x; b = y;
    accepted = 1'b0;
    n = 0;
    while (!accepted && n < 100) begin
      @(negedge clock);
      accepted = in_ready;
      if (accepted) begin
        exp_q.push_back(pack_exp(ez));
        accept_cnt++;
      end
      @(posedge clock);
      #1;
      n++;
    end
    if (!accepted) check("in_accept_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
    op = 3'($urandom_range(0, 7));
    a = $urandom;
    b = $urandom;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      cycles(1);
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // Output monitor / scoreboard compare.
  always @(negedge clock) begin
    if (!clear && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 64'd1, 64'd0);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        check("z", 64'(z), 64'(e[33:2]));
        check("zero_flag", 64'(zero_flag), 64'(e[1]));
        check("ones_flag", 64'(ones_flag), 64'(e[0]));
      end
    end
  end

  initial begin
    logic [31:0] ops_a, ops_b, z_hold;
    logic [31:0] ops_exp[8];
    int          acc_before;

    ops_exp = '{32'h0000_000A, 32'h0000_000F, 32'h0000_0005, 32'hFFFF_FFF0,
                32'hFFFF_FFF5, 32'hFFFF_FFFA, 32'hFFFF_FFF0, 32'h0000_0004};
    clear = 1'b1;
    in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b1;
    in8_valid = 1'b0; op8 = '0; a8 = '0; b8 = '0; out8_ready = 1'b1;
    stream_done = 1'b0;
    cycles(2);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_z", 64'(z), 64'd0);
    check("rst_zero_flag", 64'(zero_flag), 64'd1);
    check("rst_ones_flag", 64'(ones_flag), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    clear = 1'b0;
    cycles(1);

    // OR with exact two-cycle latency.
    send(3'b001, 32'hFFFF_FFFC, 32'hFFFF_FFFD, 32'hFFFF_FFFD);
    check("lat_not_yet", 64'(out_valid), 64'd0);
    cycles(1);
    check("lat_out_valid", 64'(out_valid), 64'd1);
    check("lat_z", 64'(z), 64'hFFFF_FFFD);
    drain();

    // All eight ops back to back on fixed operands.
    ops_a = 32'h0000_000F;
    ops_b = 32'h0000_000A;
    for (int i = 0; i < 8; i++) send(3'(i), ops_a, ops_b, ops_exp[i]);
    drain();

    // Boundary values.
    send(3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd32);
    send(3'b000, 32'd0, 32'd0, 32'd0);
    send(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    drain();

    // Backpressure: out_ready low for 3 cycles while 4 ops are offered.
    out_ready = 1'b0;
    acc_before = accept_cnt;
    z_hold = '0;
    fork
      begin
        send(3'b010, 32'h1234_5678, 32'h0F0F_0F0F, model(3'b010, 32'h1234_5678, 32'h0F0F_0F0F));
        send(3'b000, 32'hDEAD_BEEF, 32'hFFFF_0000, model(3'b000, 32'hDEAD_BEEF, 32'hFFFF_0000));
        send(3'b111, 32'h0000_00FF, 32'h0000_FF00, model(3'b111, 32'h0000_00FF, 32'h0000_FF00));
        send(3'b101, 32'hAAAA_AAAA, 32'h5555_5555, model(3'b101, 32'hAAAA_AAAA, 32'h5555_5555));
      end
      begin
        cycles(2);
        z_hold = z;
        check("stall_out_valid", 64'(out_valid), 64'd1);
        check("stall_z_first", 64'(z), 64'(model(3'b010, 32'h1234_5678, 32'h0F0F_0F0F)));
        cycles(1);
        check("stall_accepts", 64'(accept_cnt - acc_before), 64'd2);
        check("stall_in_ready", 64'(in_ready), 64'd0);
        check("stall_z_hold", 64'(z), 64'(z_hold));
        check("stall_valid_hold", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
      end
    join
    drain();
    check("stall_all_accepted", 64'(accept_cnt - acc_before), 64'd4);

    // Clear right after a transfer discards it.
    send(3'b001, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF);
    clear = 1'b1;
    #1;
    exp_q.delete();
    check("clr_out_valid", 64'(out_valid), 64'd0);
    check("clr_z", 64'(z), 64'd0);
    check("clr_zero_flag", 64'(zero_flag), 64'd1);
    check("clr_ones_flag", 64'(ones_flag), 64'd0);
    check("clr_in_ready", 64'(in_ready), 64'd1);
    cycles(2);
    clear = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycles(1);
      check("post_clr_no_out", 64'(out_valid), 64'd0);
    end

    // Randomised stream with random backpressure.
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic [2:0]  f;
          logic [31:0] x, y;
          f = 3'($urandom_range(0, 7));
          x = $urandom;
          y = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
          send(f, x, y, model(f, x, y));
        end
        stream_done = 1'b1;
      end
      begin
        while (!stream_done) begin
          out_ready = ($urandom_range(0, 2) != 0);
          cycles(1);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // 8-bit instance: popcount of 0xFF is 8.
    in8_valid = 1'b1; op8 = 3'b111; a8 = 8'hFF; b8 = 8'h00;
    @(negedge clock);
    check("w8_in_ready", 64'(in8_ready), 64'd1);
    @(posedge clock);
    #1;
    in8_valid = 1'b0; a8 = 8'h00;
    cycles(1);
    check("w8_out_valid", 64'(out8_valid), 64'd1);
    check("w8_z", 64'(z8), 64'h08);
    check("w8_zero_flag", 64'(zero8), 64'd0);
    check("w8_ones_flag", 64'(ones8), 64'd0);

    cycles(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
